// File: rtl/f_pc_gen_pkg.sv
// ----------------------------------------------------------------------------
// f_pc_gen_pkg
// Shared definitions for the fetch-stage PC generator:
//   - npc_op_e : D-stage next-PC operation encoding (2 bits)
//   - DEF_RESET_PC / DEF_EXC_PC : default reset and exception handler vectors
// ----------------------------------------------------------------------------
package f_pc_gen_pkg;

  typedef enum logic [1:0] {
    NPC_SEQ = 2'd0,  // pc_F + 4
    NPC_B   = 2'd1,  // conditional branch, taken when b_taken
    NPC_J   = 2'd2,  // jump with 26-bit instruction index
    NPC_JR  = 2'd3   // jump register
  } npc_op_e;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] DEF_EXC_PC   = 32'h0000_4180;

endpackage : f_pc_gen_pkg

// File: rtl/f_npc_sel.sv
// ----------------------------------------------------------------------------
// f_npc_sel
// Purely combinational next-state logic for the fetch PC: computes every
// candidate target and applies the priority
//   exception > ERET (held while stalled) > pending ERET > stall > D-stage op.
// Ports:
//   pc_F, eret_pend, hold      : current register state from the top level
//   stall_F, req, eret, epc    : hazard unit / exception controller inputs
//   pc_D, npc_op, b_taken,
//   imm26, rs_val              : D-stage control-flow inputs
//   pc_next, eret_pend_next,
//   hold_next                  : next values for the top-level registers
// ----------------------------------------------------------------------------
module f_npc_sel
  import f_pc_gen_pkg::*;
#(
  parameter int          ADDR_W    = 32,
  parameter logic [31:0] EXC_PC    = DEF_EXC_PC,
  parameter bit          ERET_ADD4 = 1'b1
) (
  input  logic [ADDR_W-1:0] pc_F,
  input  logic              eret_pend,
  input  logic [ADDR_W-1:0] hold,
  input  logic              stall_F,
  input  logic              req,
  input  logic              eret,
  input  logic [ADDR_W-1:0] epc,
  input  logic [ADDR_W-1:0] pc_D,
  input  logic [1:0]        npc_op,
  input  logic              b_taken,
  input  logic [25:0]       imm26,
  input  logic [ADDR_W-1:0] rs_val,
  output logic [ADDR_W-1:0] pc_next,
  output logic              eret_pend_next,
  output logic [ADDR_W-1:0] hold_next
);

  localparam logic [ADDR_W-1:0] EXC_VEC = EXC_PC[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] FOUR    = ADDR_W'(4);

  logic [ADDR_W-1:0] seq_tgt;
  logic [ADDR_W-1:0] br_off;
  logic [ADDR_W-1:0] br_tgt;
  logic [ADDR_W-1:0] jmp_tgt;
  logic [ADDR_W-1:0] eret_tgt;

  assign seq_tgt  = pc_F + FOUR;
  // Word offset: sign-extend the 16-bit immediate and scale by 4.
  assign br_off   = {{(ADDR_W-18){imm26[15]}}, imm26[15:0], 2'b00};
  assign br_tgt   = pc_D + FOUR + br_off;
  assign eret_tgt = ERET_ADD4 ? (epc + FOUR) : epc;

  // With a 28-bit PC the instruction index covers the whole address, so there
  // are no upper pc_D bits to splice in.
  generate
    if (ADDR_W > 28) begin : g_jmp_region
      assign jmp_tgt = {pc_D[ADDR_W-1:28], imm26, 2'b00};
    end else begin : g_jmp_full
      assign jmp_tgt = {imm26, 2'b00};
    end
  endgenerate

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    pc_next        = pc_F;
    eret_pend_next = eret_pend;
    hold_next      = hold;

    if (req) begin
      // Exception entry overrides stalls and discards any pending ERET.
      pc_next        = EXC_VEC;
      eret_pend_next = 1'b0;
    end else if (eret && stall_F) begin
      // Park the ERET target until fetch is released; a later ERET overwrites.
      eret_pend_next = 1'b1;
      hold_next      = eret_tgt;
    end else if (eret) begin
      pc_next        = eret_tgt;
      eret_pend_next = 1'b0;
    end else if (eret_pend && !stall_F) begin
      pc_next        = hold;
      eret_pend_next = 1'b0;
    end else if (!stall_F) begin
      case (npc_op_e'(npc_op))
        NPC_B:   pc_next = b_taken ? br_tgt : seq_tgt;
        NPC_J:   pc_next = jmp_tgt;
        NPC_JR:  pc_next = rs_val;
        default: pc_next = seq_tgt;
      endcase
    end
  end

endmodule : f_npc_sel

// File: rtl/f_pc_gen.sv
// ----------------------------------------------------------------------------
// f_pc_gen
// Fetch-stage program-counter generator. Holds the fetch PC, the pending-ERET
// flag and the held ERET target; flags fetch-address errors (AdEL) on pc_F.
// Ports:
//   clk, reset (sync, active-low)
//   stall_F             : hold PC (hazard unit)
//   req, eret, epc      : exception entry / ERET from the M-stage controller
//   pc_D, npc_op, b_taken, imm26, rs_val : D-stage control-flow inputs
//   pc_F                : registered fetch PC
//   exc_adel_F          : pc_F misaligned or outside [IMEM_LO, IMEM_HI]
//   eret_pend           : an ERET redirect is held awaiting stall release
// ----------------------------------------------------------------------------
module f_pc_gen
  import f_pc_gen_pkg::*;
#(
  parameter int          ADDR_W    = 32,
  parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
  parameter logic [31:0] EXC_PC    = DEF_EXC_PC,
  parameter bit          ERET_ADD4 = 1'b1,
  parameter logic [31:0] IMEM_LO   = 32'h0000_3000,
  parameter logic [31:0] IMEM_HI   = 32'h0000_6FFC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall_F,
  input  logic              req,
  input  logic              eret,
  input  logic [ADDR_W-1:0] epc,
  input  logic [ADDR_W-1:0] pc_D,
  input  logic [1:0]        npc_op,
  input  logic              b_taken,
  input  logic [25:0]       imm26,
  input  logic [ADDR_W-1:0] rs_val,
  output logic [ADDR_W-1:0] pc_F,
  output logic              exc_adel_F,
  output logic              eret_pend
);

  logic [ADDR_W-1:0] hold;
  logic [ADDR_W-1:0] pc_next;
  logic              eret_pend_next;
  logic [ADDR_W-1:0] hold_next;
  logic [31:0]       pc_ext;

  f_npc_sel #(
    .ADDR_W    (ADDR_W),
    .EXC_PC    (EXC_PC),
    .ERET_ADD4 (ERET_ADD4)
  ) u_npc_sel (
    .pc_F           (pc_F),
    .eret_pend      (eret_pend),
    .hold           (hold),
    .stall_F        (stall_F),
    .req            (req),
    .eret           (eret),
    .epc            (epc),
    .pc_D           (pc_D),
    .npc_op         (npc_op),
    .b_taken        (b_taken),
    .imm26          (imm26),
    .rs_val         (rs_val),
    .pc_next        (pc_next),
    .eret_pend_next (eret_pend_next),
    .hold_next      (hold_next)
  );

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge value of its inputs regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_F      <= RESET_PC[ADDR_W-1:0];
      eret_pend <= 1'b0;
      hold      <= '0;
    end else begin
      pc_F      <= pc_next;
      eret_pend <= eret_pend_next;
      hold      <= hold_next;
    end
  end

  // Range limits are 32-bit, so compare against the zero-extended PC.
  assign pc_ext     = 32'(pc_F);
  assign exc_adel_F = (pc_F[1:0] != 2'b00) || (pc_ext < IMEM_LO) || (pc_ext > IMEM_HI);

endmodule : f_pc_gen
